// File: rtl/cic_decim_sched.sv
// -----------------------------------------------------------------------------
// cic_decim_sched
//
// Rate scheduler for a single CIC decimator (N integrators, N combs of delay M).
// Converts a sparse input-sample strobe into the filter's input-rate (fil_eni)
// and output-rate (fil_eno) clock enables for a runtime-programmable ratio.
// A ratio change resets and flushes the filter; the first N*M+1 decimated
// outputs after a flush are treated as warm-up and never flagged valid.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high
//   in_valid   one-cycle strobe: new sample present on the CIC input
//   cfg_r      requested decimation ratio, sampled when cfg_wr=1
//   cfg_wr     one-cycle request to load cfg_r (ignored while cfg_busy)
//   cfg_busy   high while the filter is being flushed
//   cur_r      ratio currently in force
//   phase      input samples accepted in the current output period
//   fil_rst    synchronous reset to the CIC
//   fil_eni    CIC input-rate enable
//   fil_eno    CIC output-rate enable
//   out_valid  CIC output register holds a valid decimated sample
//   drop_cnt   input strobes discarded during flush (saturating)
// -----------------------------------------------------------------------------
module cic_decim_sched #(
   parameter  int RMAX      = 64,
   parameter  int R_DEF     = 4,
   parameter  int N         = 2,
   parameter  int M         = 1,
   parameter  int FLUSH_CYC = 4,
   localparam int RW        = $clog2(RMAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [RW-1:0] cfg_r,
   input  logic          cfg_wr,
   output logic          cfg_busy,
   output logic [RW-1:0] cur_r,
   output logic [RW-1:0] phase,
   output logic          fil_rst,
   output logic          fil_eni,
   output logic          fil_eno,
   output logic          out_valid,
   output logic [15:0]   drop_cnt
);

   localparam int WARM = N * M + 1;
   localparam int WW   = $clog2(WARM + 1);
   localparam int FW   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic [1:0] {
      S_FLUSH  = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [FW-1:0] flush_cnt;
   logic [WW-1:0] warm_cnt;
   logic          cfg_acc;
   logic          last_phase;

   function automatic logic [RW-1:0] clamp_r(input logic [RW-1:0] r);
      if (r < RW'(2))
         return RW'(2);
      else if (r > RW'(RMAX))
         return RW'(RMAX);
      else
         return r;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign last_phase = (phase == cur_r - RW'(1));

   // Enables are combinational so the CIC sees them in the same cycle as the
   // strobe. A configuration accept always wins over a coincident sample.
   always_comb begin
      state_nxt = state;
      cfg_busy  = rst;
      fil_rst   = rst;
      cfg_acc   = 1'b0;
      fil_eni   = 1'b0;
      fil_eno   = 1'b0;
      case (state)
         S_FLUSH: begin
            cfg_busy = 1'b1;
            fil_rst  = 1'b1;
            if (flush_cnt == FW'(FLUSH_CYC - 1))
               state_nxt = S_WARMUP;
         end
         S_WARMUP, S_RUN: begin
            cfg_acc = cfg_wr & ~rst;
            fil_eni = in_valid & ~cfg_acc & ~rst;
            fil_eno = fil_eni & last_phase;
            if (cfg_acc)
               state_nxt = S_FLUSH;
            else if (state == S_WARMUP && fil_eno && warm_cnt == WW'(WARM - 1))
               state_nxt = S_RUN;
         end
         default: state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_FLUSH;
      else
         state <= state_nxt;
   end

   // Counters, ratio register and the registered output-valid flag
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt <= '0;
         warm_cnt  <= '0;
         cur_r     <= RW'(R_DEF);
         phase     <= '0;
         drop_cnt  <= '0;
         out_valid <= 1'b0;
      end else begin
         // The CIC output register updates on the eno edge, so valid lags by one.
         out_valid <= fil_eno & (state == S_RUN);
         if (state == S_FLUSH) begin
            if (in_valid)
               drop_cnt <= sat_inc16(drop_cnt);
            if (flush_cnt == FW'(FLUSH_CYC - 1)) begin
               flush_cnt <= '0;
               phase     <= '0;
               warm_cnt  <= '0;
            end else begin
               flush_cnt <= flush_cnt + FW'(1);
            end
         end else if (cfg_acc) begin
            cur_r     <= clamp_r(cfg_r);
            flush_cnt <= '0;
         end else if (fil_eni) begin
            phase <= last_phase ? '0 : phase + RW'(1);
            if (state == S_WARMUP && fil_eno)
               warm_cnt <= warm_cnt + WW'(1);
         end
      end
   end

endmodule

// File: tb/tb_cic_decim_sched.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_sched
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// mode, remaining flush cycles, remaining warm-up pulses, phase, ratio and drop
// count; a compare process checks every DUT output against it on each falling
// edge. Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_cic_decim_sched;

   localparam int RMAX      = 64;
   localparam int R_DEF     = 4;
   localparam int N         = 2;
   localparam int M         = 1;
   localparam int FLUSH_CYC = 4;
   localparam int RW        = $clog2(RMAX + 1);
   localparam int WARM      = N * M + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [RW-1:0] cfg_r;
   logic          cfg_wr;
   logic          cfg_busy;
   logic [RW-1:0] cur_r;
   logic [RW-1:0] phase;
   logic          fil_rst;
   logic          fil_eni;
   logic          fil_eno;
   logic          out_valid;
   logic [15:0]   drop_cnt;

   cic_decim_sched #(
      .RMAX(RMAX), .R_DEF(R_DEF), .N(N), .M(M), .FLUSH_CYC(FLUSH_CYC)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .cfg_r(cfg_r), .cfg_wr(cfg_wr),
      .cfg_busy(cfg_busy), .cur_r(cur_r), .phase(phase), .fil_rst(fil_rst),
      .fil_eni(fil_eni), .fil_eno(fil_eno), .out_valid(out_valid), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_mode: 0 = flushing, 1 = warming up, 2 = running
   int m_mode      = 0;
   int m_flush     = 0;
   int m_warm_left = WARM;
   int m_ph        = 0;
   int m_r         = R_DEF;
   int m_drop      = 0;
   bit m_ov        = 1'b0;

   function automatic int clampr(input int v);
      if (v < 2) return 2;
      if (v > RMAX) return RMAX;
      return v;
   endfunction

   function automatic bit m_busy();
      return rst || m_mode == 0;
   endfunction

   function automatic bit m_acc();
      return cfg_wr && !m_busy();
   endfunction

   function automatic bit m_eni();
      return in_valid && !m_busy() && !cfg_wr;
   endfunction

   function automatic bit m_eno();
      return m_eni() && (m_ph == m_r - 1);
   endfunction

   task automatic model_step();
      bit eni, eno, acc;
      eni = m_eni();
      eno = m_eno();
      acc = m_acc();
      if (rst) begin
         m_mode = 0; m_flush = 0; m_r = R_DEF; m_ph = 0; m_drop = 0; m_ov = 1'b0;
      end else begin
         m_ov = eno && m_mode == 2;
         if (m_mode == 0) begin
            if (in_valid && m_drop < 65535) m_drop++;
            m_flush++;
            if (m_flush == FLUSH_CYC) begin
               m_mode = 1; m_ph = 0; m_warm_left = WARM;
            end
         end else if (acc) begin
            m_r = clampr(int'(cfg_r)); m_mode = 0; m_flush = 0;
         end else if (eni) begin
            m_ph = (m_ph + 1) % m_r;
            if (eno && m_mode == 1) begin
               m_warm_left--;
               if (m_warm_left == 0) m_mode = 2;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("fil_rst",   int'(fil_rst),   int'(rst || m_mode == 0));
         chk("cfg_busy",  int'(cfg_busy),  int'(m_busy()));
         chk("fil_eni",   int'(fil_eni),   int'(m_eni()));
         chk("fil_eno",   int'(fil_eno),   int'(m_eno()));
         chk("out_valid", int'(out_valid), int'(m_ov));
         chk("cur_r",     int'(cur_r),     m_r);
         chk("drop_cnt",  int'(drop_cnt),  m_drop);
         if (m_mode != 0)
            chk("phase", int'(phase), m_ph);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input int v);
      cfg_r  = RW'(v);
      cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
   endtask

   int n;
   int cnt;
   int tv[7] = '{1, 0, 127, 72, 17, 2, 64};
   int te[7] = '{2, 2, 64, 64, 17, 2, 64};

   initial begin
      rst = 1'b1; in_valid = 1'b0; cfg_wr = 1'b0; cfg_r = '0;
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      chk("reset_cur_r",   int'(cur_r),     4);
      chk("reset_drop",    int'(drop_cnt),  0);
      chk("reset_ov",      int'(out_valid), 0);
      chk("reset_fil_rst", int'(fil_rst),   1);
      chk("reset_busy",    int'(cfg_busy),  1);

      // Scenario 1: strobe every cycle from reset release
      rst = 1'b0; in_valid = 1'b1;
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      chk("s1_first_ov_latency", n, 20);
      chk("s1_drop_cnt", int'(drop_cnt), 4);
      cnt = 0;
      repeat (16) begin tick(); cnt += int'(out_valid); end
      chk("s1_ov_per_16", cnt, 4);

      // Scenario 2: strobe every 3rd cycle
      cnt = 0;
      for (int i = 0; i < 48; i++) begin
         in_valid = (i % 3 == 0);
         #1;
         cnt += int'(fil_eno);
         tick();
      end
      chk("s2_eno_count", cnt, 4);

      // Scenario 3: reconfigure to 8 while running
      in_valid = 1'b0;
      write_cfg(8);
      in_valid = 1'b1;
      chk("s3_cur_r", int'(cur_r), 8);
      n = 0;
      while (cfg_busy && n < 20) begin n++; tick(); end
      chk("s3_busy_cycles", n, 4);
      while (!out_valid && n < 200) begin tick(); n++; end
      chk("s3_ov_latency", n, 36);

      // Scenario 4: ratio clamping
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         write_cfg(tv[i]);
         chk("s4_clamp", int'(cur_r), te[i]);
         repeat (FLUSH_CYC) tick();
      end

      // Scenario 5a: write during flush is ignored
      cfg_r = RW'(5); cfg_wr = 1'b1;
      tick();
      cfg_r = RW'(9);
      tick();
      cfg_wr = 1'b0;
      chk("s5_busy_write_ignored", int'(cur_r), 5);
      repeat (3) tick();

      // Scenario 5b: write on an eno cycle suppresses eno and out_valid
      write_cfg(2);
      repeat (FLUSH_CYC) tick();
      in_valid = 1'b1;
      n = 0;
      while (!(m_mode == 2 && m_ph == 1) && n < 100) begin tick(); n++; end
      chk("s5_reached_run", int'(n < 100), 1);
      cfg_r = RW'(3); cfg_wr = 1'b1;
      #1;
      chk("s5_eno_blocked", int'(fil_eno), 0);
      chk("s5_eni_blocked", int'(fil_eni), 0);
      tick();
      cfg_wr = 1'b0; in_valid = 1'b0;
      chk("s5_ov_blocked", int'(out_valid), 0);
      chk("s5_cur_r", int'(cur_r), 3);

      // Scenario 6: reset pulse mid-run with phase 2
      repeat (FLUSH_CYC) tick();
      in_valid = 1'b1;
      n = 0;
      while (!(m_mode == 2 && m_ph == 2) && n < 200) begin tick(); n++; end
      in_valid = 1'b0;
      chk("s6_phase_before", int'(phase), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s6_phase",    int'(phase),     0);
      chk("s6_cur_r",    int'(cur_r),     R_DEF);
      chk("s6_drop",     int'(drop_cnt),  0);
      chk("s6_ov",       int'(out_valid), 0);
      in_valid = 1'b1;
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      chk("s6_rewarm_latency", n, 20);

      // Randomized run
      for (int i = 0; i < 3000; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         cfg_wr   = ($urandom_range(0, 39) == 0);
         cfg_r    = ($urandom_range(0, 3) == 0) ? RW'($urandom_range(0, 127))
                                                : RW'($urandom_range(0, 8));
         rst      = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; cfg_wr = 1'b0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
